// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic package: FSM state encoding and
// a constant-width helper for the divider step counter.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle for the sequential divider.
// master: start, dividend, divisor out; busy, done, quotient,
// remainder, div_by_zero in. slave is the mirror.
interface seq_restoring_divider_if #(
  parameter int N = 4
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_cla.sv
// W-bit carry-lookahead subtractor: diff_o = a_i - b_i as
// a_i + ~b_i + 1. Ports: a_i, b_i in; diff_o, co_o (1 = no borrow).
module cla_sub_n #(
  parameter int W = 5
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         co_o
);

  logic [W-1:0] bn;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;

  assign bn = ~b_i;
  assign g  = a_i & bn;
  assign p  = a_i ^ bn;

  // Each carry is a flat sum of products over all lower
  // generate/propagate terms; carry-in is a constant 1.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < W; i++) begin
      logic t;
      logic pp;
      t  = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = t | pp;
    end
  end

  assign diff_o = p ^ c[W-1:0];
  assign co_o   = c[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned N-bit restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), bus (slave: start/operands in, results out).
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int N = 4
) (
  input logic                   clk,
  input logic                   rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = clog2(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  div_q, div_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // R stays below the divisor, so N bits hold it between
  // steps; the shifted value needs the extra top bit.
  logic [N:0] r_sh;
  logic [N:0] t;
  logic       co;
  logic       unused_t_msb;

  assign r_sh = {1'b0, r_q, q_q[N-1]};

  cla_sub_n #(
    .W(N + 1)
  ) u_sub (
    .a_i   (r_sh),
    .b_i   ({1'b0, div_q}),
    .diff_o(t),
    .co_o  (co)
  );

  // On no-borrow the difference is below the divisor.
  assign unused_t_msb = t[N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          div_d = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = CW'(N - 1);
          dbz_d = 1'b0;
          if (bus.divisor == '0) state_d = DONE;
          else state_d = RUN;
        end
      end
      RUN: begin
        r_d = co ? t[N-1:0] : r_sh[N-1:0];
        q_d = {q_q[N-2:0], co};
        if (cnt_q == '0) state_d = DONE;
        else cnt_d = cnt_q - CW'(1);
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        // Zero divisor skips RUN, so Q still holds the dividend.
        if (div_q == '0) begin
          quo_d = '1;
          rem_d = q_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = q_q;
          rem_d = r_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (N=4)
// against a plain a/b, a%b reference model.
module tb_seq_restoring_divider;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider_if #(.N(N)) bus ();

  seq_restoring_divider #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [N-1:0] mq(input logic [N-1:0] a, b);
    return (b == 0) ? {N{1'b1}} : a / b;
  endfunction

  function automatic logic [N-1:0] mr(input logic [N-1:0] a, b);
    return (b == 0) ? a : a % b;
  endfunction

  function automatic int mlat(input logic [N-1:0] b);
    return (b == 0) ? 1 : N + 1;
  endfunction

  // Issue one request, scramble operands after acceptance,
  // wait (bounded) for done. lat=-1 on timeout.
  task automatic run_op(input logic [N-1:0] a, b,
                        output logic [N-1:0] q, r,
                        output logic dz, output int lat,
                        output logic busy_seen);
    int k;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = N'($urandom);
    @(negedge clk);
    k         = cyc;
    lat       = -1;
    busy_seen = 1'b0;
    q         = '0;
    r         = '0;
    dz        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        lat = cyc - k;
        q   = bus.quotient;
        r   = bus.remainder;
        dz  = bus.div_by_zero;
        break;
      end
      busy_seen = busy_seen | bus.busy;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", bus.done);
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset_outs got q=%h r=%h dbz=%b want 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] va[5] = '{4'd13, 4'd7, 4'd3, 4'd0, 4'd15};
    logic [N-1:0] vb[5] = '{4'd3, 4'd0, 4'd9, 4'd5, 4'd1};
    logic [N-1:0] q, r;
    logic dz, bs;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], q, r, dz, lat, bs);
      checks++;
      if ({q, r, dz} !== {mq(va[i], vb[i]), mr(va[i], vb[i]), vb[i] == 0}) begin
        errors++;
        $display("FAIL dir_%0d/%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=%b",
                 va[i], vb[i], q, r, dz, mq(va[i], vb[i]), mr(va[i], vb[i]),
                 vb[i] == 0);
      end
      checks++;
      if (lat !== mlat(vb[i])) begin
        errors++;
        $display("FAIL dir_lat_%0d/%0d got %0d want %0d",
                 va[i], vb[i], lat, mlat(vb[i]));
      end
      checks++;
      if (bs !== (vb[i] != 0)) begin
        errors++;
        $display("FAIL dir_busy_%0d/%0d got %b want %b",
                 va[i], vb[i], bs, vb[i] != 0);
      end
    end
  endtask

  task automatic test_midrun_start();
    int pulses;
    logic [N-1:0] q, r;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd2;
    bus.divisor  = 4'd1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    pulses = 0;
    q = '0;
    r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        q = bus.quotient;
        r = bus.remainder;
      end
    end
    checks++;
    if ({q, r} !== {4'd4, 4'd1}) begin
      errors++;
      $display("FAIL midrun_result got q=%0d r=%0d want q=4 r=1", q, r);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL midrun_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_midrun();
    logic [N-1:0] q, r;
    logic dz, bs;
    int lat;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
      errors++;
      $display("FAIL rst_midrun got busy=%b done=%b q=%h r=%h dbz=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    run_op(4'd9, 4'd2, q, r, dz, lat, bs);
    checks++;
    if ({q, r, dz, lat} !== {4'd4, 4'd1, 1'b0, N + 1}) begin
      errors++;
      $display("FAIL rst_then_9/2 got q=%0d r=%0d dbz=%b lat=%0d want q=4 r=1 dbz=0 lat=%0d",
               q, r, dz, lat, N + 1);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, r;
    logic dz, bs;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      run_op(a, b, q, r, dz, lat, bs);
      checks++;
      if ({q, r, dz, lat} !== {mq(a, b), mr(a, b), b == 0, mlat(b)}) begin
        errors++;
        $display("FAIL rand_%0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                 a, b, q, r, dz, lat, mq(a, b), mr(a, b), b == 0, mlat(b));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b, q, r;
    logic dz, bs;
    int lat;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        a = N'(ia);
        b = N'(ib);
        run_op(a, b, q, r, dz, lat, bs);
        checks++;
        if ({q, r, dz, lat} !== {mq(a, b), mr(a, b), b == 0, mlat(b)}) begin
          errors++;
          $display("FAIL sweep_%0d/%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=%b lat=%0d",
                   a, b, q, r, dz, lat, mq(a, b), mr(a, b), b == 0, mlat(b));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_midrun_start();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
